sdram_arbit: RTL and testbench
==============================

// Module: sdram_arbit
// PURPOSE
// - Shares the single SDRAM command/address/data bus among four masters: init, auto-refresh,
//   burst write and burst read. Sits inside sdram_ctrl, between those engines and the SDRAM pins.
// - Grants one master at a time, muxes its command onto the pins and drives the dq tristate.
// - Alternates write/read fairness so neither FIFO side starves.
// PARAMETERS
// - ADDR_W  13  SDRAM row/column address width
// - BA_W    2   bank address width
// - DATA_W  16  dq width
// PORTS
// - sys_clk        in   1       100 MHz clock, same as the SDRAM clock domain
// - sys_rst        in   1       asynchronous, active-high reset
// - init_end       in   1       init engine done; level-high, sticky after it first rises
// - init_cmd/ba/addr  in  4/BA_W/ADDR_W  init engine bus {cs_n,ras_n,cas_n,we_n}
// - aref_req       in   1       refresh request; held by requester until aref_en
// - aref_end       in   1       1-cycle pulse: refresh sequence finished
// - aref_cmd/ba/addr  in  4/BA_W/ADDR_W  refresh engine bus
// - wr_req         in   1       write request; held until wr_en
// - wr_end         in   1       1-cycle pulse: write burst + precharge finished
// - wr_cmd/ba/addr in   4/BA_W/ADDR_W  write engine bus
// - wr_sdram_en    in   1       write engine drives dq this cycle
// - wr_sdram_data  in   DATA_W  write data
// - rd_req         in   1       read request; held until rd_en
// - rd_end         in   1       1-cycle pulse: read burst finished
// - rd_cmd/ba/addr in   4/BA_W/ADDR_W  read engine bus
// - aref_en/wr_en/rd_en  out 1  grant, high for the whole time the state is AREF/WRITE/READ
// - sdram_rd_data  out  DATA_W  sdram_dq, passed through unregistered
// - sdram_cke      out  1       clock enable; constant 1
// - sdram_cs_n/ras_n/cas_n/we_n  out 1  command pins
// - sdram_ba       out  BA_W    bank address
// - sdram_addr     out  ADDR_W  address
// - sdram_dq       inout DATA_W data bus
// BEHAVIOUR
// - States: INIT, ARBIT, AREF, WRITE, READ. Reset -> INIT; all grants 0.
// - Reset outputs: cmd NOP (4'b0111), ba all-ones, addr all-ones, dq high-Z.
// - INIT -> ARBIT on the first cycle init_end=1. Pins carry init_* while in INIT.
//   INIT is re-entered only via reset.
// - ARBIT: pins carry NOP, ba/addr all-ones. Priority: aref_req first, then write/read.
// - Write/read tie-break when both are requested: the master not granted last wins.
//   The last_wr flag resets to 0, so the first tie goes to write.
// - Stay in ARBIT while no request is pending.
// - Transition latency: state is registered; a grant rises on the cycle after the request is
//   seen in ARBIT. Every grant is preceded by at least 1 ARBIT (NOP) cycle.
// - AREF/WRITE/READ: hold, with the pins muxed combinationally from that engine's bus,
//   until the matching *_end pulse. Return to ARBIT on the next edge; the grant drops then.
// - No preemption. aref_req arriving during WRITE/READ waits; the engines are responsible for
//   shortening their bursts when they see it.
// - An *_end pulse from a non-granted master is ignored.
// - Requests seen in the same cycle as *_end are not granted until the ARBIT cycle.
// - sdram_dq = wr_sdram_en && state==WRITE ? wr_sdram_data : 'z. wr_sdram_en outside WRITE
//   is ignored (never drive dq).
// - sys_rst mid-burst: immediately INIT, NOP, dq released, grants 0.
// - Conflicting requests during INIT are ignored until init_end.
// STRUCTURE
// - Package sdram_pkg: the command constants CMD_NOP/ACT/RD/WR/PRE/AREF/MRS as 4-bit
//   {cs_n,ras_n,cas_n,we_n}, and the arbiter state encoding.
// - Sub-module sdram_arbit_cmd_mux: a purely combinational state-indexed mux of cmd/ba/addr
//   plus the dq tristate. The FSM and fairness flag stay in sdram_arbit.
// TESTING
// - Reset with init_end=0 while driving init_cmd=MRS (4'b0000):
//   pins = 0000 in INIT. Raise init_end -> pins = NOP on the next cycle.
// - aref_req, wr_req and rd_req all high in ARBIT:
//   aref_en first; after aref_end -> 1 NOP cycle -> wr_en; after wr_end -> 1 NOP -> rd_en.
// - wr_req and rd_req continuously high for 4 rounds: the grants alternate W,R,W,R.
//   No two consecutive same-type grants.
// - During WRITE with wr_sdram_en=1 and data 16'hA5A5: sdram_dq = A5A5.
//   rd_end pulse during WRITE -> no state change. After wr_end -> dq = Z.
// - aref_req raised mid-READ: rd_en stays high until rd_end.
//   aref_en rises exactly 2 cycles after rd_end (one ARBIT cycle in between).
// - Assert sys_rst during READ: same cycle rd_en=0, pins NOP, dq = Z.
//   After release -> INIT until init_end.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and the arbiter state type.
// Commands are packed as {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// Bundle between the four SDRAM engines and the arbiter, plus the muxed SDRAM pins.
// master = engine/controller side, slave = arbiter side.
interface sdram_arbit_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DATA_W = 16
);

  logic              init_end;
  logic [3:0]        init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;

  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [BA_W-1:0]   aref_ba;
  logic [ADDR_W-1:0] aref_addr;

  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;

  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;

  logic              aref_en;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] sdram_rd_data;
  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;

  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en, sdram_rd_data, sdram_cke,
    input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );

  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en, sdram_rd_data, sdram_cke,
    output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );

endinterface

// File: rtl/sdram_arbit_cmd_mux.sv
// Combinational pin mux: selects the owning engine's cmd/ba/addr by arbiter state
// and drives dq only while the write engine owns the bus and asks for it.
module sdram_arbit_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DATA_W = 16
) (
  input  logic              rst,
  input  arb_state_t        state,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        cmd,
  output logic [BA_W-1:0]   ba,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] dq
);

  logic dq_oe;

  // Reset overrides INIT so the pins sit at NOP while reset is held.
  always_comb begin
    cmd  = CMD_NOP;
    ba   = '1;
    addr = '1;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          cmd  = init_cmd;
          ba   = init_ba;
          addr = init_addr;
        end
        ST_AREF: begin
          cmd  = aref_cmd;
          ba   = aref_ba;
          addr = aref_addr;
        end
        ST_WRITE: begin
          cmd  = wr_cmd;
          ba   = wr_ba;
          addr = wr_addr;
        end
        ST_READ: begin
          cmd  = rd_cmd;
          ba   = rd_ba;
          addr = rd_addr;
        end
        default: begin
          cmd  = CMD_NOP;
          ba   = '1;
          addr = '1;
        end
      endcase
    end
  end

  assign dq_oe = !rst && (state == ST_WRITE) && wr_sdram_en;
  assign dq    = dq_oe ? wr_sdram_data : {DATA_W{1'bz}};

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: grants init / auto-refresh / write / read ownership of the
// command bus, refresh first, with write/read alternating on ties.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DATA_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  sdram_arbit_if.slave      bus,
  inout  wire  [DATA_W-1:0] sdram_dq
);

  arb_state_t state_reg, state_next;
  logic       last_wr_reg, last_wr_next;
  logic [3:0] cmd;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg   <= ST_INIT;
      last_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_wr_reg <= last_wr_next;
    end
  end

  // A write wins a tie only if the previous data grant was a read (or none yet).
  always_comb begin
    state_next   = state_reg;
    last_wr_next = last_wr_reg;
    case (state_reg)
      ST_INIT: begin
        if (bus.init_end) state_next = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (bus.aref_req) begin
          state_next = ST_AREF;
        end else if (bus.wr_req && (!bus.rd_req || !last_wr_reg)) begin
          state_next   = ST_WRITE;
          last_wr_next = 1'b1;
        end else if (bus.rd_req) begin
          state_next   = ST_READ;
          last_wr_next = 1'b0;
        end
      end
      ST_AREF: begin
        if (bus.aref_end) state_next = ST_ARBIT;
      end
      ST_WRITE: begin
        if (bus.wr_end) state_next = ST_ARBIT;
      end
      ST_READ: begin
        if (bus.rd_end) state_next = ST_ARBIT;
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_comb begin
    bus.aref_en = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    case (state_reg)
      ST_AREF:  bus.aref_en = 1'b1;
      ST_WRITE: bus.wr_en   = 1'b1;
      ST_READ:  bus.rd_en   = 1'b1;
      default: begin
        bus.aref_en = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
      end
    endcase
  end

  sdram_arbit_cmd_mux #(
    .ADDR_W (ADDR_W),
    .BA_W   (BA_W),
    .DATA_W (DATA_W)
  ) u_cmd_mux (
    .rst           (sys_rst),
    .state         (state_reg),
    .init_cmd      (bus.init_cmd),
    .init_ba       (bus.init_ba),
    .init_addr     (bus.init_addr),
    .aref_cmd      (bus.aref_cmd),
    .aref_ba       (bus.aref_ba),
    .aref_addr     (bus.aref_addr),
    .wr_cmd        (bus.wr_cmd),
    .wr_ba         (bus.wr_ba),
    .wr_addr       (bus.wr_addr),
    .wr_sdram_en   (bus.wr_sdram_en),
    .wr_sdram_data (bus.wr_sdram_data),
    .rd_cmd        (bus.rd_cmd),
    .rd_ba         (bus.rd_ba),
    .rd_addr       (bus.rd_addr),
    .cmd           (cmd),
    .ba            (bus.sdram_ba),
    .addr          (bus.sdram_addr),
    .dq            (sdram_dq)
  );

  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd;
  assign bus.sdram_cke     = 1'b1;
  assign bus.sdram_rd_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: engine-behaviour stimulus, an ownership-level reference
// model and a per-cycle scoreboard checked on the falling edge.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int AW = 13;
  localparam int BW = 2;
  localparam int DW = 16;

  // Who owns the bus in the reference model.
  localparam int O_AREF = 0;
  localparam int O_WR   = 1;
  localparam int O_RD   = 2;
  localparam int O_IDLE = 3;
  localparam int O_INIT = 4;

  typedef struct packed {
    logic [2:0]    en;   // {rd, wr, aref}
    logic [3:0]    cmd;
    logic [BW-1:0] ba;
    logic [AW-1:0] addr;
    logic [DW-1:0] dq;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  wire  [DW-1:0] sdram_dq;
  logic          tb_oe;
  logic [DW-1:0] tb_val;
  assign sdram_dq = tb_oe ? tb_val : {DW{1'bz}};

  sdram_arbit_if #(.ADDR_W(AW), .BA_W(BW), .DATA_W(DW)) bus ();

  sdram_arbit #(.ADDR_W(AW), .BA_W(BW), .DATA_W(DW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus),
    .sdram_dq (sdram_dq)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model and engine-behaviour state.
  int            owner;
  bit            last_wr;
  bit            pend[3];
  bit            req_d[3];
  bit            auto_req[3];
  bit            end_v[3];
  int            cnt[3];
  int            blen[3];
  bit            rnd, spur, fix_data;
  bit            rst_next, init_end_v, init_end_d, wen_v;
  logic [DW-1:0] wdata_v;
  logic [3:0]    cmd_v[4];
  logic [BW-1:0] ba_v[4];
  logic [AW-1:0] addr_v[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership rules applied at each rising edge to the inputs of the closing cycle.
  task automatic model_edge();
    if (sys_rst) begin
      owner   = O_INIT;
      last_wr = 1'b0;
    end else begin
      case (owner)
        O_INIT: if (init_end_d) owner = O_IDLE;
        O_IDLE: begin
          if (req_d[0])                 owner = O_AREF;
          else if (req_d[1] && req_d[2]) owner = last_wr ? O_RD : O_WR;
          else if (req_d[1])            owner = O_WR;
          else if (req_d[2])            owner = O_RD;
          if (owner == O_WR) last_wr = 1'b1;
          else if (owner == O_RD) last_wr = 1'b0;
        end
        default: if (end_v[owner]) owner = O_IDLE;
      endcase
    end
  endtask

  task automatic push_exp();
    exp_t e;
    bit   drv;
    int   src;
    e.en = {owner == O_RD, owner == O_WR, owner == O_AREF};
    if (sys_rst || owner == O_IDLE) begin
      e.cmd  = CMD_NOP;
      e.ba   = '1;
      e.addr = '1;
    end else begin
      src    = (owner == O_INIT) ? 3 : owner;
      e.cmd  = cmd_v[src];
      e.ba   = ba_v[src];
      e.addr = addr_v[src];
    end
    drv    = !sys_rst && owner == O_WR && wen_v;
    tb_oe  = !drv;
    tb_val = DW'($urandom);
    e.dq   = drv ? wdata_v : tb_val;
    sb.push_back(e);
  endtask

  task automatic drive();
    sys_rst = rst_next;
    if (sys_rst) begin
      owner      = O_INIT;
      last_wr    = 1'b0;
      init_end_v = 1'b0;
      for (int m = 0; m < 3; m++) pend[m] = 1'b0;
    end
    for (int m = 0; m < 3; m++) begin
      if (owner == m) begin
        pend[m] = 1'b0;
        cnt[m]++;
        if (rnd && cnt[m] == 1) blen[m] = $urandom_range(1, 6);
        end_v[m] = (cnt[m] == blen[m]);
      end else begin
        cnt[m] = 0;
        if (!sys_rst && (auto_req[m] || (rnd && $urandom_range(0, 5) == 0))) pend[m] = 1'b1;
        end_v[m] = !sys_rst && spur && ($urandom_range(0, 4) == 0);
      end
      req_d[m] = pend[m];
    end
    init_end_d = init_end_v;
    for (int i = 0; i < 4; i++) begin
      cmd_v[i]  = 4'($urandom);
      ba_v[i]   = BW'($urandom);
      addr_v[i] = AW'($urandom);
    end
    wen_v   = fix_data ? 1'b1 : 1'($urandom_range(0, 1));
    wdata_v = fix_data ? 16'hA5A5 : DW'($urandom);

    bus.init_end      = init_end_d;
    bus.init_cmd      = cmd_v[3];
    bus.init_ba       = ba_v[3];
    bus.init_addr     = addr_v[3];
    bus.aref_req      = req_d[0];
    bus.aref_end      = end_v[0];
    bus.aref_cmd      = cmd_v[0];
    bus.aref_ba       = ba_v[0];
    bus.aref_addr     = addr_v[0];
    bus.wr_req        = req_d[1];
    bus.wr_end        = end_v[1];
    bus.wr_cmd        = cmd_v[1];
    bus.wr_ba         = ba_v[1];
    bus.wr_addr       = addr_v[1];
    bus.wr_sdram_en   = wen_v;
    bus.wr_sdram_data = wdata_v;
    bus.rd_req        = req_d[2];
    bus.rd_end        = end_v[2];
    bus.rd_cmd        = cmd_v[2];
    bus.rd_ba         = ba_v[2];
    bus.rd_addr       = addr_v[2];
    push_exp();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      model_edge();
      #1;
      drive();
    end
  endtask

  always @(negedge sys_clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("grant", 32'({bus.rd_en, bus.wr_en, bus.aref_en}), 32'(mon_e.en));
      chk("cmd", 32'({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n}),
          32'(mon_e.cmd));
      chk("ba", 32'(bus.sdram_ba), 32'(mon_e.ba));
      chk("addr", 32'(bus.sdram_addr), 32'(mon_e.addr));
      chk("dq", 32'(bus.sdram_rd_data), 32'(mon_e.dq));
      chk("cke", 32'(bus.sdram_cke), 32'd1);
    end
  end

  initial begin
    sys_rst = 1'b1;
    tb_oe = 1'b1;
    tb_val = '0;
    owner = O_INIT;
    last_wr = 1'b0;
    rnd = 1'b0;
    spur = 1'b0;
    fix_data = 1'b0;
    init_end_v = 1'b0;
    init_end_d = 1'b0;
    rst_next = 1'b1;
    for (int m = 0; m < 3; m++) begin
      pend[m] = 1'b0; req_d[m] = 1'b0; auto_req[m] = 1'b0;
      end_v[m] = 1'b0; cnt[m] = 0; blen[m] = 3;
    end

    // Reset, INIT carrying the init bus, then release to ARBIT.
    cycles(3);
    rst_next = 1'b0;
    cycles(3);
    init_end_v = 1'b1;
    cycles(3);

    // All three requesting at once: refresh, then write, then read.
    for (int m = 0; m < 3; m++) pend[m] = 1'b1;
    cycles(20);

    // Write and read held continuously: grants must alternate.
    auto_req[1] = 1'b1;
    auto_req[2] = 1'b1;
    cycles(36);
    auto_req[1] = 1'b0;
    auto_req[2] = 1'b0;
    cycles(10);

    // Write burst with fixed data and stray end pulses from other masters.
    fix_data = 1'b1;
    spur = 1'b1;
    pend[1] = 1'b1;
    cycles(8);
    fix_data = 1'b0;
    spur = 1'b0;
    cycles(2);

    // Refresh requested in the middle of a read.
    blen[2] = 5;
    pend[2] = 1'b1;
    cycles(3);
    pend[0] = 1'b1;
    cycles(12);

    // Reset asserted during a read, then INIT until init_end.
    pend[2] = 1'b1;
    cycles(3);
    rst_next = 1'b1;
    cycles(2);
    rst_next = 1'b0;
    cycles(4);
    init_end_v = 1'b1;
    cycles(3);

    // Randomised traffic with occasional resets.
    rnd = 1'b1;
    spur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (sys_rst) rst_next = 1'b0;
      else rst_next = ($urandom_range(0, 399) == 0);
      if (!init_end_v && !sys_rst && $urandom_range(0, 3) == 0) init_end_v = 1'b1;
      cycles(1);
    end

    @(negedge sys_clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
